reply_arbiter: RTL and testbench

Round-robin arbiter that shares the single host reply byte stream between several reply sources, such as command echo, SI read-back and rate report. Each source holds a complete reply packet, requests the channel, and streams the packet once granted. The arbiter forwards exactly one packet at a time. It enforces an inter-packet gap, a start timeout and a maximum packet length. It sits between the command/reply generators and the host transmit framer.

---
 rtl/reply_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_reply_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reply_arbiter.sv
// reply_arbiter: round-robin owner of the host reply byte stream.
// One source at a time is granted and its packet is forwarded with one cycle
// of latency. The arbiter enforces a start timeout after grant, a maximum
// forwarded length per packet and a fixed idle gap after every packet or abort.
module reply_arbiter #(
    parameter int N_REQ    = 4,
    parameter int GAP      = 4,
    parameter int START_TO = 64,
    parameter int MAX_LEN  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     gnt,
    input  logic [8*N_REQ-1:0]   din,
    input  logic [N_REQ-1:0]     din_en,
    output logic [7:0]           dout,
    output logic                 dout_en,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overlen_err
);

    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT    = 2'd1;
    localparam logic [1:0] ST_XFER     = 2'd2;
    localparam logic [1:0] ST_GAP_WAIT = 2'd3;

    // Counters compare against "last" values so the exit happens on the
    // cycle that completes the required count.
    localparam logic [15:0]      START_LAST = 16'(START_TO - 1);
    localparam logic [15:0]      GAP_LAST   = 16'(GAP - 1);
    localparam logic [15:0]      LEN_LIMIT  = 16'(MAX_LEN);
    localparam logic [SEL_W-1:0] SEL_MAX    = SEL_W'(N_REQ - 1);

    // First requester at or above p, wrapping at N_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] p);
        logic [2*N_REQ-1:0] rot;
        logic [SEL_W-1:0]   off;
        logic               found;
        int unsigned        pos;
        rot   = {r, r} >> p;
        off   = {SEL_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                off   = SEL_W'(k);
                found = 1'b1;
            end else begin
                off   = off;
                found = found;
            end
        end
        pos = 32'(p) + 32'(off);
        if (pos >= 32'(N_REQ)) begin
            pos = pos - 32'(N_REQ);
        end else begin
            pos = pos;
        end
        return SEL_W'(pos);
    endfunction

    // Round-robin successor of the source that just released the channel.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] s);
        logic [SEL_W-1:0] n;
        if (s == SEL_MAX) begin
            n = {SEL_W{1'b0}};
        end else begin
            n = s + SEL_W'(1);
        end
        return n;
    endfunction

    // One-hot grant vector for source s.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [N_REQ-1:0] v;
        v    = {N_REQ{1'b0}};
        v[s] = 1'b1;
        return v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_en_q, dout_en_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic             overlen_err_q, overlen_err_d;
    logic             ovl_seen_q, ovl_seen_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;

    logic [SEL_W-1:0] pick_s;
    logic             src_en_s;
    logic [7:0]       src_byte_s;

    // Only the selected source's byte lane and valid are ever looked at.
    always_comb begin
        pick_s     = rr_pick(req, ptr_q);
        src_en_s   = din_en[sel_q];
        src_byte_s = din[{sel_q, 3'b000} +: 8];
    end

    // Next-state, forwarding and counter logic for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_d         = sel_q;
        gnt_d         = gnt_q;
        dout_d        = 8'h00;
        dout_en_d     = 1'b0;
        timeout_err_d = 1'b0;
        overlen_err_d = 1'b0;
        ovl_seen_d    = ovl_seen_q;
        wait_cnt_d    = wait_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    sel_d      = pick_s;
                    gnt_d      = onehot(pick_s);
                    state_d    = ST_GRANT;
                    wait_cnt_d = 16'd0;
                    byte_cnt_d = 16'd0;
                    ovl_seen_d = 1'b0;
                end else begin
                    gnt_d = {N_REQ{1'b0}};
                end
            end

            ST_GRANT: begin
                // Timeout takes priority over a byte arriving on the same edge.
                if (wait_cnt_q >= START_LAST) begin
                    timeout_err_d = 1'b1;
                    gnt_d         = {N_REQ{1'b0}};
                    ptr_d         = next_ptr(sel_q);
                    gap_cnt_d     = 16'd0;
                    state_d       = ST_GAP_WAIT;
                end else if (src_en_s) begin
                    dout_d     = src_byte_s;
                    dout_en_d  = 1'b1;
                    byte_cnt_d = 16'd1;
                    state_d    = ST_XFER;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            ST_XFER: begin
                if (src_en_s) begin
                    if (byte_cnt_q < LEN_LIMIT) begin
                        dout_d     = src_byte_s;
                        dout_en_d  = 1'b1;
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end else begin
                        // Over-length: drop the byte, flag only the first drop,
                        // keep ownership until the source ends its packet.
                        byte_cnt_d    = byte_cnt_q;
                        overlen_err_d = ~ovl_seen_q;
                        ovl_seen_d    = 1'b1;
                    end
                end else begin
                    gnt_d     = {N_REQ{1'b0}};
                    ptr_d     = next_ptr(sel_q);
                    gap_cnt_d = 16'd0;
                    state_d   = ST_GAP_WAIT;
                end
            end

            ST_GAP_WAIT: begin
                // Requests are not considered until the gap has elapsed.
                if (gap_cnt_q >= GAP_LAST) begin
                    gap_cnt_d = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            default: begin
                gnt_d   = {N_REQ{1'b0}};
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= {SEL_W{1'b0}};
            sel_q         <= {SEL_W{1'b0}};
            gnt_q         <= {N_REQ{1'b0}};
            dout_q        <= 8'h00;
            dout_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overlen_err_q <= 1'b0;
            ovl_seen_q    <= 1'b0;
            wait_cnt_q    <= 16'd0;
            byte_cnt_q    <= 16'd0;
            gap_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            sel_q         <= sel_d;
            gnt_q         <= gnt_d;
            dout_q        <= dout_d;
            dout_en_q     <= dout_en_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overlen_err_q <= overlen_err_d;
            ovl_seen_q    <= ovl_seen_d;
            wait_cnt_q    <= wait_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign dout        = dout_q;
    assign dout_en     = dout_en_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overlen_err = overlen_err_q;

endmodule

// File: tb/tb_reply_arbiter.sv
// Directed bench for reply_arbiter: default instance plus a MAX_LEN=8 instance
// sharing the same stimulus for the over-length case.
module tb_reply_arbiter;

    localparam int GAP      = 4;
    localparam int START_TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  din_en;
    logic [7:0]  src_byte [4];
    logic [31:0] din;

    logic [3:0]  gnt,   o_gnt;
    logic [7:0]  dout,  o_dout;
    logic        dout_en, busy, timeout_err, overlen_err;
    logic        o_dout_en, o_busy, o_timeout_err, o_overlen_err;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int g0, e0, g2, e2, g3, e3, gc, ec;
    int to_k, to_cnt, gk;
    int obad, ovl_cnt, ovl_idx, gbad, main_cnt;

    always_comb din = {src_byte[3], src_byte[2], src_byte[1], src_byte[0]};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    reply_arbiter #(.N_REQ(4), .GAP(GAP), .START_TO(START_TO), .MAX_LEN(1024)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .din(din), .din_en(din_en),
        .dout(dout), .dout_en(dout_en), .busy(busy),
        .timeout_err(timeout_err), .overlen_err(overlen_err)
    );

    reply_arbiter #(.N_REQ(4), .GAP(GAP), .START_TO(START_TO), .MAX_LEN(8)) dut_ovl (
        .clk(clk), .rst(rst), .req(req), .gnt(o_gnt), .din(din), .din_en(din_en),
        .dout(o_dout), .dout_en(o_dout_en), .busy(o_busy),
        .timeout_err(o_timeout_err), .overlen_err(o_overlen_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req    = 4'b0000;
        din_en = 4'b0000;
        for (int i = 0; i < 4; i++) src_byte[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_grant(input string tag, output int gcyc);
        int k;
        k = 0;
        while (gnt == 4'b0000 && k < 50) begin
            step();
            k++;
        end
        check_val({tag, "_granted"}, 32'(gnt != 4'b0000), 32'd1);
        gcyc = cyc;
    endtask

    // Wait for grant of source s, stream n bytes base+i, then end the packet.
    task automatic serve(input string tag, input int s, input int n, input logic [7:0] base,
                         input logic [3:0] raise_mask, input logic noise,
                         output int gcyc, output int ecyc);
        int         bad;
        logic [3:0] exp_g;
        logic [7:0] exp_b;
        exp_g = 4'b0001 << s;
        wait_grant(tag, gcyc);
        check_val({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
        bad = 0;
        for (int i = 0; i < n; i++) begin
            exp_b       = base + 8'(i);
            src_byte[s] = exp_b;
            din_en[s]   = 1'b1;
            if (i == 2) req = req | raise_mask;
            if (noise) din_en[2] = ~din_en[2];
            step();
            if (dout !== exp_b || dout_en !== 1'b1 || gnt !== exp_g) bad++;
        end
        din_en[s]   = 1'b0;
        req[s]      = 1'b0;
        src_byte[s] = 8'h00;
        step();
        check_val({tag, "_data"}, 32'(bad), 32'd0);
        check_val({tag, "_gnt_clear"}, 32'(gnt), 32'd0);
        check_val({tag, "_dout_en_low"}, 32'(dout_en), 32'd0);
        ecyc = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_dout", 32'(dout), 32'd0);
        check_val("rst_dout_en", 32'(dout_en), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_timeout", 32'(timeout_err), 32'd0);
        check_val("rst_overlen", 32'(overlen_err), 32'd0);
        rst = 1'b0;
        step();

        // Single source 1, 11-byte packet, then the gap
        req[1] = 1'b1;
        step();
        check_val("t1_gnt_latency", 32'(gnt), 32'h2);
        check_val("t1_busy_rise", 32'(busy), 32'd1);
        serve("t1", 1, 11, 8'h04, 4'b0000, 1'b0, gc, ec);
        check_val("t1_busy_in_gap", 32'(busy), 32'd1);
        for (int j = 1; j < GAP; j++) step();
        check_val("t1_busy_gap_end", 32'(busy), 32'd1);
        step();
        check_val("t1_busy_fall", 32'(busy), 32'd0);

        // Sources 0 and 2 simultaneously; req0 re-raised during source 2
        do_reset();
        req = 4'b0101;
        serve("t2_a", 0, 5, 8'h10, 4'b0000, 1'b0, g0, e0);
        serve("t2_b", 2, 5, 8'h20, 4'b0001, 1'b0, g2, e2);
        serve("t2_c", 0, 5, 8'h30, 4'b0000, 1'b0, g3, e3);
        check_val("t2_gap_ab", 32'(g2 - e0), 32'(GAP + 1));
        check_val("t2_gap_bc", 32'(g3 - e2), 32'(GAP + 1));

        // Source 3 never sends: timeout, late din_en ignored, then source 0
        do_reset();
        req = 4'b1000;
        wait_grant("t3", gc);
        check_val("t3_gnt", 32'(gnt), 32'h8);
        req[0] = 1'b1;
        to_k = 0; to_cnt = 0; gk = 0;
        for (int k = 1; k <= 75; k++) begin
            step();
            if (timeout_err === 1'b1) begin
                to_cnt++;
                if (to_k == 0) to_k = k;
            end
            if (gnt === 4'b0001 && gk == 0) gk = k;
            if (k == START_TO) begin
                check_val("t3_late_byte_dropped", 32'(dout_en), 32'd0);
                check_val("t3_gnt_clear", 32'(gnt), 32'd0);
            end
            if (k == START_TO - 1) begin
                din_en[3]   = 1'b1;
                src_byte[3] = 8'h5A;
            end
            if (k == START_TO) din_en[3] = 1'b0;
        end
        check_val("t3_timeout_cycle", 32'(to_k), 32'(START_TO));
        check_val("t3_timeout_pulses", 32'(to_cnt), 32'd1);
        check_val("t3_next_gnt_src0", 32'(gk), 32'(START_TO + GAP + 1));

        // Over-length on the MAX_LEN=8 instance: 12 bytes from source 0
        do_reset();
        req = 4'b0001;
        wait_grant("t4", gc);
        check_val("t4_gnt", 32'(o_gnt), 32'h1);
        obad = 0; ovl_cnt = 0; ovl_idx = -1; gbad = 0; main_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            src_byte[0] = 8'h40 + 8'(i);
            din_en[0]   = 1'b1;
            step();
            if (i < 8) begin
                if (o_dout !== 8'h40 + 8'(i) || o_dout_en !== 1'b1) obad++;
            end else begin
                if (o_dout !== 8'h00 || o_dout_en !== 1'b0) obad++;
            end
            if (o_overlen_err === 1'b1) begin
                ovl_cnt++;
                if (ovl_idx < 0) ovl_idx = i;
            end
            if (o_gnt !== 4'b0001) gbad++;
            if (dout_en === 1'b1) main_cnt++;
        end
        din_en[0] = 1'b0;
        req       = 4'b0000;
        step();
        check_val("t4_fwd_data", 32'(obad), 32'd0);
        check_val("t4_overlen_pulses", 32'(ovl_cnt), 32'd1);
        check_val("t4_overlen_byte", 32'(ovl_idx), 32'd8);
        check_val("t4_gnt_held", 32'(gbad), 32'd0);
        check_val("t4_gnt_clear", 32'(o_gnt), 32'd0);
        check_val("t4_full_len_main", 32'(main_cnt), 32'd12);

        // Source 2 toggles din_en with 0xAA while source 1 streams
        do_reset();
        src_byte[2] = 8'hAA;
        req = 4'b0010;
        serve("t5", 1, 6, 8'h60, 4'b0000, 1'b1, gc, ec);
        din_en[2] = 1'b0;

        // Asynchronous reset mid-packet after a source 2 packet moved ptr to 3
        do_reset();
        req = 4'b0100;
        serve("t6_pre", 2, 2, 8'h70, 4'b0000, 1'b0, gc, ec);
        for (int j = 0; j < GAP; j++) step();
        req = 4'b0010;
        wait_grant("t6", gc);
        check_val("t6_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 3; i++) begin
            src_byte[1] = 8'h80 + 8'(i);
            din_en[1]   = 1'b1;
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_async_gnt", 32'(gnt), 32'd0);
        check_val("t6_async_dout_en", 32'(dout_en), 32'd0);
        check_val("t6_async_busy", 32'(busy), 32'd0);
        check_val("t6_async_dout", 32'(dout), 32'd0);
        din_en = 4'b0000;
        req    = 4'b1010;
        step();
        rst = 1'b0;
        step();
        check_val("t6_regrant_ptr0", 32'(gnt), 32'h2);
        check_val("t6_no_timeout", 32'(timeout_err), 32'd0);
        check_val("t6_no_overlen", 32'(overlen_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
